// File: rtl/demux_pkg.sv
// Shared definitions for the 1-by-3 registered demultiplexer.
// Optional drop counter is enabled with macro DEMUX_DROP_CNT_EN.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH_DEF = 34;
  localparam int unsigned NUM_CH          = 3;
  localparam logic [1:0]  SEL_DROP        = 2'b11;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry channel register with load/valid/ready handshake.
// 'space' tells the upstream side a load would be accepted this cycle.
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             space
);

  ch_state_e        state;
  ch_state_e        state_nxt;
  logic [WIDTH-1:0] data_q;

  // Entry state register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CH_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Data register only changes on a load, so it holds while stalled or idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

  // Next-state logic: fill on load, drain on ready, refill on both.
  always_comb begin
    state_nxt = state;
    case (state)
      CH_EMPTY: if (load) state_nxt = CH_FULL;
      CH_FULL:  if (out_ready && !load) state_nxt = CH_EMPTY;
      default:  state_nxt = CH_EMPTY;
    endcase
  end

  // Handshake outputs derived from the registered state.
  always_comb begin
    out_valid = (state == CH_FULL);
    space     = (state == CH_EMPTY) || out_ready;
  end

  assign out_data = data_q;

endmodule

// File: rtl/demux_1_by_3_reg.sv
// 1-by-3 registered demultiplexer; in_sel 2'b11 discards the word.
// Define DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_1_by_3_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             out_valid_0,
  output logic             out_valid_1,
  output logic             out_valid_2,
  input  logic             out_ready_0,
  input  logic             out_ready_1,
  input  logic             out_ready_2,
  output logic [WIDTH-1:0] out_data_0,
  output logic [WIDTH-1:0] out_data_1,
  output logic [WIDTH-1:0] out_data_2
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  logic [NUM_CH-1:0] ch_ready;
  logic [NUM_CH-1:0] ch_valid;
  logic [NUM_CH-1:0] ch_space;
  logic [NUM_CH-1:0] ch_load;
  logic [WIDTH-1:0]  ch_data [NUM_CH];
  logic              accept;

  assign ch_ready = {out_ready_2, out_ready_1, out_ready_0};

  // Readiness for the selected destination; discards are always taken.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'b00:   in_ready = ch_space[0];
      2'b01:   in_ready = ch_space[1];
      2'b10:   in_ready = ch_space[2];
      default: in_ready = 1'b1;
    endcase
  end

  // Gating loads with rst_n keeps words out of the channels during reset.
  always_comb begin
    accept = in_valid && in_ready && rst_n;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_load[k] = accept && (in_sel == 2'(k));

    demux_chan_reg #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ch_load[k]),
      .load_data (in_data),
      .out_ready (ch_ready[k]),
      .out_valid (ch_valid[k]),
      .out_data  (ch_data[k]),
      .space     (ch_space[k])
    );
  end

  assign out_valid_0 = ch_valid[0];
  assign out_valid_1 = ch_valid[1];
  assign out_valid_2 = ch_valid[2];
  assign out_data_0  = ch_data[0];
  assign out_data_1  = ch_data[1];
  assign out_data_2  = ch_data[2];

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of discarded words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (accept && (in_sel == SEL_DROP) && (drop_q != '1)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_1_by_3_reg.sv
// Self-checking bench for demux_1_by_3_reg (directed vector table plus
// hand-written stall/drop sequences). Drop counter checks need DEMUX_DROP_CNT_EN.
module tb_demux_1_by_3_reg;

  localparam int W = 34;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         out_valid_0, out_valid_1, out_valid_2;
  logic         out_ready_0, out_ready_1, out_ready_2;
  logic [W-1:0] out_data_0, out_data_1, out_data_2;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  demux_1_by_3_reg #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .out_valid_0 (out_valid_0),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_ready_0 (out_ready_0),
    .out_ready_1 (out_ready_1),
    .out_ready_2 (out_ready_2),
    .out_data_0  (out_data_0),
    .out_data_1  (out_data_1),
    .out_data_2  (out_data_2)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  typedef struct {
    logic         rst_n;
    logic         vld;
    logic [1:0]   sel;
    logic [W-1:0] din;
    logic [2:0]   rdy;      // {out_ready_2, out_ready_1, out_ready_0}
    logic         chk_rdy;
    logic         exp_rdy;  // in_ready before the edge
    logic [2:0]   exp_vld;  // out_valid after the edge
    logic [W-1:0] exp_d0;
    logic [W-1:0] exp_d1;
    logic [W-1:0] exp_d2;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic [1:0] s,
                       input logic [W-1:0] d, input logic [2:0] rd);
    rst_n       = r;
    in_valid    = v;
    in_sel      = s;
    in_data     = d;
    out_ready_0 = rd[0];
    out_ready_1 = rd[1];
    out_ready_2 = rd[2];
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst v  sel    din              rdy    chk rdy  vld     d0     d1              d2
    vecs[0]  = '{1'b0,1'b0,2'b00,34'h0,          3'b000,1'b0,1'b0,3'b000,34'h0, 34'h0,          34'h0};
    vecs[1]  = '{1'b0,1'b0,2'b00,34'h0,          3'b000,1'b1,1'b1,3'b000,34'h0, 34'h0,          34'h0};
    vecs[2]  = '{1'b1,1'b1,2'b01,34'h0_1234_5678,3'b010,1'b1,1'b1,3'b010,34'h0, 34'h0_1234_5678,34'h0};
    vecs[3]  = '{1'b1,1'b0,2'b01,34'h0,          3'b010,1'b1,1'b1,3'b000,34'h0, 34'h0_1234_5678,34'h0};
    vecs[4]  = '{1'b1,1'b1,2'b10,34'h3_0000_0001,3'b000,1'b1,1'b1,3'b100,34'h0, 34'h0_1234_5678,34'h3_0000_0001};
    vecs[5]  = '{1'b1,1'b1,2'b10,34'h3_0000_0002,3'b000,1'b1,1'b0,3'b100,34'h0, 34'h0_1234_5678,34'h3_0000_0001};
    vecs[6]  = '{1'b1,1'b1,2'b10,34'h3_0000_0002,3'b000,1'b1,1'b0,3'b100,34'h0, 34'h0_1234_5678,34'h3_0000_0001};
    vecs[7]  = '{1'b1,1'b1,2'b10,34'h3_0000_0002,3'b100,1'b1,1'b1,3'b100,34'h0, 34'h0_1234_5678,34'h3_0000_0002};
    vecs[8]  = '{1'b1,1'b0,2'b10,34'h0,          3'b100,1'b1,1'b1,3'b000,34'h0, 34'h0_1234_5678,34'h3_0000_0002};
    vecs[9]  = '{1'b1,1'b1,2'b00,34'h1,          3'b000,1'b1,1'b1,3'b001,34'h1, 34'h0_1234_5678,34'h3_0000_0002};
    vecs[10] = '{1'b1,1'b1,2'b00,34'h2,          3'b001,1'b1,1'b1,3'b001,34'h2, 34'h0_1234_5678,34'h3_0000_0002};
    vecs[11] = '{1'b1,1'b0,2'b00,34'h0,          3'b001,1'b1,1'b1,3'b000,34'h2, 34'h0_1234_5678,34'h3_0000_0002};
    vecs[12] = '{1'b1,1'b1,2'b01,34'h55,         3'b000,1'b1,1'b1,3'b010,34'h2, 34'h55,         34'h3_0000_0002};
    vecs[13] = '{1'b1,1'b1,2'b00,34'h66,         3'b000,1'b1,1'b1,3'b011,34'h66,34'h55,         34'h3_0000_0002};
    vecs[14] = '{1'b1,1'b1,2'b10,34'h77,         3'b000,1'b1,1'b1,3'b111,34'h66,34'h55,         34'h77};
    vecs[15] = '{1'b1,1'b1,2'b01,34'h88,         3'b000,1'b1,1'b0,3'b111,34'h66,34'h55,         34'h77};
    vecs[16] = '{1'b1,1'b1,2'b11,34'h99,         3'b000,1'b1,1'b1,3'b111,34'h66,34'h55,         34'h77};
    vecs[17] = '{1'b0,1'b1,2'b00,34'hAA,         3'b111,1'b1,1'b1,3'b000,34'h0, 34'h0,          34'h0};
    vecs[18] = '{1'b1,1'b0,2'b00,34'h0,          3'b000,1'b1,1'b1,3'b000,34'h0, 34'h0,          34'h0};
    vecs[19] = '{1'b1,1'b1,2'b11,34'hFF,         3'b000,1'b1,1'b1,3'b000,34'h0, 34'h0,          34'h0};

    drive(1'b0, 1'b0, 2'b00, '0, 3'b000);
    #1;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst_n, vecs[i].vld, vecs[i].sel, vecs[i].din, vecs[i].rdy);
      #1;
      if (vecs[i].chk_rdy) check($sformatf("v%0d in_ready", i), W'(in_ready), W'(vecs[i].exp_rdy));
      step();
      check($sformatf("v%0d out_valid", i),
            W'({out_valid_2, out_valid_1, out_valid_0}), W'(vecs[i].exp_vld));
      check($sformatf("v%0d out_data_0", i), out_data_0, vecs[i].exp_d0);
      check($sformatf("v%0d out_data_1", i), out_data_1, vecs[i].exp_d1);
      check($sformatf("v%0d out_data_2", i), out_data_2, vecs[i].exp_d2);
    end

    // Registered outputs: changing in_data between edges must not reach out_data_0.
    drive(1'b1, 1'b1, 2'b00, 34'h2_AAAA_5555, 3'b000);
    step();
    check("load ch0", out_data_0, 34'h2_AAAA_5555);
    in_data = 34'h1_0F0F_0F0F;
    #2;
    check("no comb path", out_data_0, 34'h2_AAAA_5555);

    // Long stall on ch0 with changing offers: data and valid hold.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 1'b1, 2'b00, W'(c) + 34'h100, 3'b000);
      #1;
      check($sformatf("stall%0d in_ready", c), W'(in_ready), W'(1'b0));
      step();
      check($sformatf("stall%0d data", c), out_data_0, 34'h2_AAAA_5555);
      check($sformatf("stall%0d valid", c), W'(out_valid_0), W'(1'b1));
    end

    // Drain ch0 with no offer; idle data stays put while empty.
    drive(1'b1, 1'b0, 2'b00, 34'h3_FFFF_FFFF, 3'b001);
    step();
    check("drain valid", W'(out_valid_0), W'(1'b0));
    drive(1'b1, 1'b0, 2'b00, 34'h3_FFFF_FFFF, 3'b000);
    step();
    step();
    check("idle data hold", out_data_0, 34'h2_AAAA_5555);

`ifdef DEMUX_DROP_CNT_EN
    drive(1'b0, 1'b0, 2'b00, '0, 3'b000);
    step();
    check("drop reset", W'(drop_cnt), W'(16'd0));
    drive(1'b1, 1'b1, 2'b11, 34'h5, 3'b000);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("drop%0d in_ready", c), W'(in_ready), W'(1'b1));
      step();
      check($sformatf("drop%0d valid", c),
            W'({out_valid_2, out_valid_1, out_valid_0}), W'(3'b000));
    end
    check("drop_cnt 5", W'(drop_cnt), W'(16'd5));
    for (int c = 0; c < 65529; c++) step();
    check("drop_cnt FFFE", W'(drop_cnt), W'(16'hFFFE));
    for (int c = 0; c < 3; c++) step();
    check("drop_cnt sat", W'(drop_cnt), W'(16'hFFFF));
    drive(1'b0, 1'b0, 2'b00, '0, 3'b000);
    step();
    check("drop_cnt rst", W'(drop_cnt), W'(16'd0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
